// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the FIFO-draining UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PARITY_EN  = 0;
  localparam int DEF_STOP_BITS  = 1;
  localparam int FRAME_BITS     = 1 + DEF_DATA_WIDTH + DEF_PARITY_EN + DEF_STOP_BITS;
  localparam int PARITY_MAX_W   = 64;

  function automatic int frame_bits(input int data_width, input int parity_en,
                                    input int stop_bits);
    return 1 + data_width + parity_en + stop_bits;
  endfunction

  // Callers zero-extend narrower words; extra zeros do not change the XOR.
  function automatic logic parity_bit(input logic [PARITY_MAX_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period counter: bit_tick marks the last cycle of every serial bit.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk_read,
  input  logic rst_n,
  input  logic clear,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    if (clear || cnt_q == LAST) cnt_d = '0;
    else                        cnt_d = cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_read or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bit_tick = !clear && (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from the FIFO read port and shifts them out as async serial frames, LSB first.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk_read,
  input  logic                  rst_n,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic          ODD_BIT   = (PARITY_ODD != 0);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  logic                  rd_en_q, rd_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  baud_clear, bit_tick, can_start;

  assign can_start  = tx_en && !fifo_empty;
  // Holding the counter clear until START aligns every bit period to the start edge.
  assign baud_clear = (state_q == IDLE) || (state_q == POP) || (state_q == LOAD);

  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk_read (clk_read),
    .rst_n    (rst_n),
    .clear    (baud_clear),
    .bit_tick (bit_tick)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves a latch behind.
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE:  if (can_start) state_d = POP;
      POP:   state_d = LOAD;
      LOAD: begin
        bit_cnt_d = '0;
        if (!fifo_empty) begin
          shreg_d  = fifo_data;
          parity_d = parity_bit(PARITY_MAX_W'(fifo_data), ODD_BIT);
          state_d  = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: if (bit_tick) state_d = DATA;
      DATA: if (bit_tick) begin
        if (bit_cnt_q == LAST_DATA) begin
          bit_cnt_d = '0;
          state_d   = (PARITY_EN != 0) ? PARITY : STOP;
        end else begin
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      PARITY: if (bit_tick) state_d = STOP;
      STOP: if (bit_tick) begin
        if (bit_cnt_q == LAST_STOP) begin
          bit_cnt_d = '0;
          done_d    = 1'b1;
          // Chaining straight into POP keeps the inter-frame gap at two cycles.
          state_d   = can_start ? POP : IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase

    rd_en_d = (state_d == POP);
    busy_d  = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = parity_q;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_read or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three parity/stop configurations fed by a stale-empty FIFO model.
`timescale 1ns/1ps
module tb_fifo_uart_tx;
  import fifo_uart_pkg::*;

  localparam int C  = 4;
  localparam int ND = 3;

  logic clk_read = 1'b0;
  logic rst_n    = 1'b0;
  always #5 clk_read = ~clk_read;

  logic [ND-1:0] tx_en        = '0;
  logic [ND-1:0] manual_mode  = '0;
  logic [ND-1:0] manual_empty = '0;
  logic [ND-1:0] empty_model  = '1;
  logic [ND-1:0] fifo_empty, rd_en, tx, busy, done;
  logic [7:0]    fifo_data [ND];

  assign fifo_empty = (manual_mode & manual_empty) | (~manual_mode & empty_model);

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    dut_plain (.clk_read(clk_read), .rst_n(rst_n), .tx_en(tx_en[0]), .fifo_empty(fifo_empty[0]),
               .fifo_data(fifo_data[0]), .fifo_rd_en(rd_en[0]), .tx(tx[0]), .busy(busy[0]),
               .frame_done(done[0]));
  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    dut_even (.clk_read(clk_read), .rst_n(rst_n), .tx_en(tx_en[1]), .fifo_empty(fifo_empty[1]),
              .fifo_data(fifo_data[1]), .fifo_rd_en(rd_en[1]), .tx(tx[1]), .busy(busy[1]),
              .frame_done(done[1]));
  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2))
    dut_odd (.clk_read(clk_read), .rst_n(rst_n), .tx_en(tx_en[2]), .fifo_empty(fifo_empty[2]),
             .fifo_data(fifo_data[2]), .fifo_rd_en(rd_en[2]), .tx(tx[2]), .busy(busy[2]),
             .frame_done(done[2]));

  // FIFO model: empty reflects the occupancy before the previous edge's pop (one cycle stale).
  logic [7:0] fq [ND][$];
  always @(posedge clk_read) begin
    for (int i = 0; i < ND; i++) begin
      empty_model[i] <= (fq[i].size() == 0);
      if (rd_en[i] && fq[i].size() != 0) fifo_data[i] <= fq[i].pop_front();
    end
  end

  int cyc = 0;
  int rd_cnt [ND] = '{0, 0, 0};
  always @(posedge clk_read) cyc++;
  always @(negedge clk_read)
    for (int i = 0; i < ND; i++) if (rd_en[i] === 1'b1) rd_cnt[i]++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pe_of(input int d);  return (d == 0) ? 0 : 1; endfunction
  function automatic int sb_of(input int d);  return (d == 2) ? 2 : 1; endfunction
  function automatic int flen(input int d);   return frame_bits(8, pe_of(d), sb_of(d)); endfunction

  // Serial bit k of the frame, built from the frame-format rules.
  function automatic logic [15:0] exp_frame(input int d, input logic [7:0] w);
    logic [15:0] f = '0;
    for (int i = 0; i < 8; i++) f[1+i] = w[i];
    if (pe_of(d) != 0) f[9] = logic'(($countones(w) + ((d == 2) ? 1 : 0)) % 2);
    for (int k = 9 + pe_of(d); k < flen(d); k++) f[k] = 1'b1;
    return f;
  endfunction

  task automatic wait_pop(input int d);
    int waitc = 0;
    while (rd_en[d] !== 1'b1 && waitc < 300) begin
      @(negedge clk_read);
      waitc++;
    end
    check("pop_seen", rd_en[d], 1'b1);
  endtask

  // Entered at a negedge; returns at the negedge of the frame_done cycle.
  task automatic check_frame(input int d, input logic [7:0] w, output int t_pop);
    int L = flen(d);
    logic [15:0] obs = '0;
    int unstable = 0;
    int ctrl_bad = 0;
    wait_pop(d);
    t_pop = cyc;
    @(negedge clk_read);
    check("load_cycle", {tx[d], busy[d], rd_en[d]}, 3'b110);
    for (int k = 0; k < L * C; k++) begin
      @(negedge clk_read);
      if (k % C == 0) obs[k/C] = tx[d];
      else if (tx[d] !== obs[k/C]) unstable++;
      if (done[d] !== 1'b0 || busy[d] !== 1'b1 || rd_en[d] !== 1'b0) ctrl_bad++;
    end
    check("frame_bits", obs, exp_frame(d, w));
    check("bit_stable", unstable, 0);
    check("ctrl_in_frame", ctrl_bad, 0);
    @(negedge clk_read);
    check("frame_done", {done[d], tx[d]}, 2'b11);
  endtask

  int t0, t1, t2, rd_base, bad;
  logic [7:0] rw [5];

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk_read);
    check("reset_outputs", {tx, rd_en, busy, done}, {3'b111, 3'b000, 3'b000, 3'b000});
    rst_n = 1'b1;
    tx_en = '1;
    repeat (2) @(negedge clk_read);
    check("idle_after_reset", {tx, busy}, {3'b111, 3'b000});

    // Single word.
    rd_base = rd_cnt[0];
    fq[0].push_back(8'hA5);
    check_frame(0, 8'hA5, t0);
    check("busy_fall", busy[0], 1'b0);
    repeat (6) @(negedge clk_read);
    check("single_pop_count", rd_cnt[0] - rd_base, 1);

    // Three queued words back to back.
    fq[0].push_back(8'h01); fq[0].push_back(8'h80); fq[0].push_back(8'hFF);
    check_frame(0, 8'h01, t0);
    check_frame(0, 8'h80, t1);
    check_frame(0, 8'hFF, t2);
    check("spacing_1", t1 - t0, flen(0) * C + 2);
    check("spacing_2", t2 - t1, flen(0) * C + 2);

    // Parity: even and odd (odd config also has two stop bits).
    fq[1].push_back(8'h07);
    check_frame(1, 8'h07, t0);
    fq[2].push_back(8'h07);
    check_frame(2, 8'h07, t0);

    // tx_en dropped mid-frame.
    fq[0].push_back(8'h3C); fq[0].push_back(8'hC3);
    wait_pop(0);
    rd_base = rd_cnt[0];
    fork
      check_frame(0, 8'h3C, t0);
      begin
        repeat (11) @(negedge clk_read);
        tx_en[0] = 1'b0;
      end
    join
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_read);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
    end
    check("txen_low_idle", bad, 0);
    check("txen_low_no_pop", rd_cnt[0] - rd_base, 1);
    tx_en[0] = 1'b1;
    @(negedge clk_read);
    check("txen_resume_pop", rd_en[0], 1'b1);
    check_frame(0, 8'hC3, t0);

    // Refused read: empty seen in LOAD.
    manual_mode[1]  = 1'b1;
    manual_empty[1] = 1'b0;
    rd_base = rd_cnt[1];
    wait_pop(1);
    manual_empty[1] = 1'b1;
    @(negedge clk_read);
    check("refuse_load", {tx[1], busy[1]}, 2'b11);
    @(negedge clk_read);
    check("refuse_idle", {tx[1], busy[1]}, 2'b10);
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_read);
      if (tx[1] !== 1'b1 || busy[1] !== 1'b0) bad++;
    end
    check("refuse_stays_idle", bad, 0);
    check("refuse_pop_count", rd_cnt[1] - rd_base, 1);
    manual_mode[1] = 1'b0;

    // Random burst on the plain config.
    for (int i = 0; i < 5; i++) begin
      rw[i] = 8'($urandom);
      fq[0].push_back(rw[i]);
    end
    for (int i = 0; i < 5; i++) begin
      t1 = t0;
      check_frame(0, rw[i], t0);
      if (i > 0) check("rand_spacing", t0 - t1, flen(0) * C + 2);
    end

    // Random words with random idle gaps on the odd/two-stop config.
    for (int i = 0; i < 4; i++) begin
      rw[0] = 8'($urandom);
      fq[2].push_back(rw[0]);
      check_frame(2, rw[0], t0);
      repeat ($urandom_range(0, 5)) @(negedge clk_read);
    end

    // Reset mid-frame.
    fq[0].push_back(8'h5A);
    wait_pop(0);
    repeat (10) @(negedge clk_read);
    #2 rst_n = 1'b0;
    #1 check("reset_immediate", {tx[0], rd_en[0], busy[0], done[0]}, 4'b1000);
    fq[0].delete();
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_read);
      if ({tx, rd_en, busy, done} !== {3'b111, 9'b0}) bad++;
    end
    check("reset_held", bad, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_read);
    check("post_reset_idle", {tx[0], busy[0], rd_en[0]}, 3'b100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
